// File: rtl/nn_pkg.sv
// Shared definitions for the classifier layers: the sequencing state enum
// and the helpers that size the MAC datapath from the layer parameters.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } nn_state_t;

    // Ceiling log2; clog2(1) = 0, callers widen to at least one bit.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Signed product width plus enough headroom for hidden+1 terms.
    function automatic int acc_width(input int resolution, input int hidden_number);
        return 2 * resolution + 1 + clog2(hidden_number + 1);
    endfunction

    // Largest unsigned activation that fits in resolution bits.
    function automatic int sat_limit(input int resolution);
        return (1 << resolution) - 1;
    endfunction

endpackage

// File: rtl/output_layer.sv
// Output neuron layer: serial MAC over a synchronous weight ROM, one
// product per cycle, followed by ReLU, fixed-point shift and saturation.
// The finished vector is published together with a one-cycle digit_en.
//
// Handshake: start is a request accepted only while busy is low (IDLE);
// there is no backpressure. digit_en is a single-cycle valid marking
// output_activations as new; the vector then holds until the next pulse.
module output_layer
    import nn_pkg::*;
#(
    parameter int hidden_number = 32,
    parameter int neuron_number = 10,
    parameter int resolution    = 8,
    parameter int frac_bits     = 6
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [resolution*hidden_number-1:0]   hidden_activations,
    output logic [clog2(neuron_number*(hidden_number+1))-1:0] weight_addr,
    input  logic [resolution-1:0]                 weight_data,
    output logic                                  busy,
    output logic [resolution*neuron_number-1:0]   output_activations,
    output logic                                  digit_en,
    output logic [2:0]                            fsm_state
);

    localparam int ADDR_W = clog2(neuron_number * (hidden_number + 1));
    localparam int K_W    = (clog2(hidden_number + 1) > 0) ? clog2(hidden_number + 1) : 1;
    localparam int N_W    = (clog2(neuron_number) > 0) ? clog2(neuron_number) : 1;
    localparam int PROD_W = 2 * resolution + 1;
    localparam int ACC_W  = acc_width(resolution, hidden_number);

    localparam logic [K_W-1:0]   K_LAST  = K_W'(hidden_number);
    localparam logic [N_W-1:0]   N_LAST  = N_W'(neuron_number - 1);
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_limit(resolution));

    nn_state_t state;
    nn_state_t state_next;

    logic [resolution*hidden_number-1:0] act_q;
    logic [resolution*neuron_number-1:0] res_buf;
    logic [resolution*neuron_number-1:0] res_next;
    logic [K_W-1:0]                      k;
    logic [N_W-1:0]                      n;
    logic signed [ACC_W-1:0]             acc;

    logic [K_W-1:0]              act_idx;
    logic [resolution-1:0]       act_sel;
    logic signed [PROD_W-1:0]    act_ext;
    logic signed [PROD_W-1:0]    w_ext;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_W-1:0]     prod_acc;
    logic signed [ACC_W-1:0]     bias_acc;
    logic [ACC_W-1:0]            acc_shift;
    logic [resolution-1:0]       q_val;

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    // State register; reset returns to IDLE and aborts any run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: MAC issues H+1 addresses, DRAIN absorbs the last
    // ROM word, WRITE stores the neuron and loops or finishes.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_MAC;
            S_MAC:   if (k == K_LAST) state_next = S_DRAIN;
            S_DRAIN: state_next = S_WRITE;
            S_WRITE: state_next = (n == N_LAST) ? S_DONE : S_MAC;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The word on weight_data during MAC belongs to the address issued one
    // cycle earlier, i.e. input k-1.
    always_comb begin
        act_idx = k - K_W'(1);
        act_sel = '0;
        for (int i = 0; i < hidden_number; i++) begin
            if (K_W'(i) == act_idx) act_sel = act_q[i*resolution +: resolution];
        end
    end

    // Product and bias terms aligned to the same binary point.
    always_comb begin
        act_ext  = {{(resolution + 1){1'b0}}, act_sel};
        w_ext    = {{(resolution + 1){weight_data[resolution-1]}}, weight_data};
        prod     = act_ext * w_ext;
        prod_acc = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        bias_acc = {{(ACC_W - 2*resolution){weight_data[resolution-1]}},
                    weight_data, {resolution{1'b0}}};
    end

    // ReLU, truncating shift and saturation; slot n replaced in a copy of
    // the buffer so the final neuron can be published on the same edge.
    always_comb begin
        acc_shift = ACC_W'(acc >>> frac_bits);
        if (acc[ACC_W-1]) begin
            q_val = '0;
        end else if (acc_shift > SAT_MAX) begin
            q_val = SAT_MAX[resolution-1:0];
        end else begin
            q_val = acc_shift[resolution-1:0];
        end
        res_next = res_buf;
        for (int i = 0; i < neuron_number; i++) begin
            if (N_W'(i) == n) res_next[i*resolution +: resolution] = q_val;
        end
    end

    // Datapath: counters, address, accumulator, result buffer and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q              <= '0;
            res_buf            <= '0;
            output_activations <= '0;
            digit_en           <= 1'b0;
            weight_addr        <= '0;
            k                  <= '0;
            n                  <= '0;
            acc                <= '0;
        end else begin
            digit_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        act_q       <= hidden_activations;
                        k           <= '0;
                        n           <= '0;
                        acc         <= '0;
                        weight_addr <= '0;
                    end
                end
                S_MAC: begin
                    if (k != '0) acc <= acc + prod_acc;
                    if (k != K_LAST) begin
                        k           <= k + K_W'(1);
                        weight_addr <= weight_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    acc <= acc + bias_acc;
                end
                S_WRITE: begin
                    res_buf <= res_next;
                    acc     <= '0;
                    k       <= '0;
                    if (n == N_LAST) begin
                        output_activations <= res_next;
                        digit_en           <= 1'b1;
                    end else begin
                        n           <= n + N_W'(1);
                        weight_addr <= weight_addr + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer.sv
// Directed bench for output_layer at H=4, N=3, resolution=8, frac_bits=6.
module tb_output_layer;
    import nn_pkg::*;

    localparam int H = 4;
    localparam int N = 3;
    localparam int R = 8;
    localparam int LAT = N * (H + 3);

    logic          clk;
    logic          reset;
    logic          start;
    logic [R*H-1:0] hidden_activations;
    logic [3:0]    weight_addr;
    logic [R-1:0]  weight_data;
    logic          busy;
    logic [R*N-1:0] output_activations;
    logic          digit_en;
    logic [2:0]    fsm_state;

    int total = 0;
    int bad   = 0;

    logic [R-1:0] rom [15];
    logic [3:0]   exp_q[$];

    typedef struct {
        logic [R*H-1:0]       acts;
        logic [N*(H+1)*R-1:0] img;
        logic [R*N-1:0]       exp_out;
        string                name;
    } vec_t;

    vec_t vecs[5];

    output_layer #(
        .hidden_number(H),
        .neuron_number(N),
        .resolution(R),
        .frac_bits(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .hidden_activations(hidden_activations),
        .weight_addr(weight_addr),
        .weight_data(weight_data),
        .busy(busy),
        .output_activations(output_activations),
        .digit_en(digit_en),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous ROM model, one-cycle read
    always @(posedge clk) begin
        weight_data <= (int'(weight_addr) < 15) ? rom[weight_addr] : 8'h00;
    end

    function automatic logic [39:0] nb(input int w0, input int w1, input int w2,
                                       input int w3, input int b);
        return {8'(b), 8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_rom(input logic [N*(H+1)*R-1:0] img);
        for (int a = 0; a < N*(H+1); a++) rom[a] = img[a*R +: R];
    endtask

    // Called at a negedge; returns at the negedge after edge 0.
    task automatic launch(input logic [R*H-1:0] acts);
        hidden_activations = acts;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in the cycle after edge 0; checks latency, busy, result and
    // the following drop of digit_en/busy. Returns in that following cycle.
    task automatic wait_done(input string name, input logic [R*H-1:0] acts,
                             input logic [R*N-1:0] exp_out, input bit disturb);
        int e;
        bit seen;
        bit busy_ok;
        e = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (e < 60 && !seen) begin
            if (fsm_state == S_MAC && exp_q.size() > 0) begin
                check({name, "_addr"}, 64'(weight_addr), 64'(exp_q.pop_front()));
            end
            if (!busy) busy_ok = 1'b0;
            if (digit_en) begin
                seen = 1'b1;
                start = 1'b0;
                hidden_activations = acts;
            end else begin
                if (disturb) begin
                    start = 1'b1;
                    hidden_activations = $urandom;
                end
                @(negedge clk);
                e++;
            end
        end
        check({name, "_seen"}, 64'(seen), 64'd1);
        check({name, "_latency"}, 64'(e), 64'(LAT));
        check({name, "_busy_during"}, 64'(busy_ok), 64'd1);
        check({name, "_out"}, 64'(output_activations), 64'(exp_out));
        @(negedge clk);
        check({name, "_pulse_end"}, 64'(digit_en), 64'd0);
        check({name, "_busy_end"}, 64'(busy), 64'd0);
        check({name, "_out_hold"}, 64'(output_activations), 64'(exp_out));
    endtask

    initial begin
        // test 1 / 6 style saturation and ReLU
        vecs[0].name = "sat_relu";
        vecs[0].acts = 32'hFFFF_FFFF;
        vecs[0].img  = {nb(-64, -64, -64, -64, 0), nb(0, 0, 0, 0, 0), nb(64, 64, 64, 64, 0)};
        vecs[0].exp_out = {8'd0, 8'd0, 8'd255};
        // bias handling: 16, 144, negative -> 0
        vecs[1].name = "bias";
        vecs[1].acts = 32'h1010_1010;
        vecs[1].img  = {nb(16, 16, 16, 16, -32), nb(16, 16, 16, 16, 32), nb(16, 16, 16, 16, 0)};
        vecs[1].exp_out = {8'd0, 8'd144, 8'd16};
        // extreme weights: 96772>>6 = 1512 -> 255; truncation to 15
        vecs[2].name = "extreme";
        vecs[2].acts = 32'hFFFF_FFFF;
        vecs[2].img  = {nb(2, 2, 2, 2, -4), nb(1, 1, 1, 1, 0), nb(127, 127, 127, 127, -128)};
        vecs[2].exp_out = {8'd15, 8'd15, 8'd255};
        // distinct inputs per lane: 556>>6=8, 190>>6=2, 6144>>6=96
        vecs[3].name = "mixed";
        vecs[3].acts = {8'd40, 8'd30, 8'd20, 8'd10};
        vecs[3].img  = {nb(64, 64, 64, 64, -1), nb(-1, 0, 0, 5, 0), nb(1, 2, 3, 4, 1)};
        vecs[3].exp_out = {8'd96, 8'd2, 8'd8};
        // edges: exactly 255, 256 saturates, -255 clamps
        vecs[4].name = "edges";
        vecs[4].acts = 32'h0000_00FF;
        vecs[4].img  = {nb(-1, 0, 0, 0, 0), nb(0, 0, 0, 0, 64), nb(64, 0, 0, 0, 0)};
        vecs[4].exp_out = {8'd0, 8'd255, 8'd255};

        for (int a = 0; a < 15; a++) rom[a] = 8'h00;
        reset = 1'b1;
        start = 1'b0;
        hidden_activations = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_digit_en", 64'(digit_en), 64'd0);
        check("reset_addr", 64'(weight_addr), 64'd0);
        check("reset_out", 64'(output_activations), 64'd0);
        check("reset_state", 64'(fsm_state), 64'(S_IDLE));

        // table-driven runs; the first also checks the address sequence
        for (int v = 0; v < 5; v++) begin
            if (v == 0) for (int a = 0; a < 15; a++) exp_q.push_back(4'(a));
            load_rom(vecs[v].img);
            launch(vecs[v].acts);
            wait_done(vecs[v].name, vecs[v].acts, vecs[v].exp_out, 1'b0);
            check({vecs[v].name, "_addr_all"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end

        // start and input changes while busy are ignored
        load_rom(vecs[3].img);
        launch(vecs[3].acts);
        wait_done("busy_ignore", vecs[3].acts, vecs[3].exp_out, 1'b1);
        // first cycle with busy low: immediate restart
        load_rom(vecs[1].img);
        launch(vecs[1].acts);
        check("restart_state", 64'(fsm_state), 64'(S_MAC));
        wait_done("restart", vecs[1].acts, vecs[1].exp_out, 1'b0);

        // reset at edge 10 aborts the run and clears outputs
        load_rom(vecs[2].img);
        launch(vecs[2].acts);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out", 64'(output_activations), 64'd0);
        check("abort_addr", 64'(weight_addr), 64'd0);
        begin
            bit de_seen;
            de_seen = 1'b0;
            for (int c = 0; c < 30; c++) begin
                if (digit_en) de_seen = 1'b1;
                @(negedge clk);
            end
            check("abort_no_pulse", 64'(de_seen), 64'd0);
        end
        launch(vecs[2].acts);
        wait_done("after_abort", vecs[2].acts, vecs[2].exp_out, 1'b0);

        // reset wins over start
        hidden_activations = vecs[0].acts;
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("reset_wins_busy", 64'(busy), 64'd0);
        check("reset_wins_out", 64'(output_activations), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
